mesh_traffic_gen: RTL and testbench

Synthesizable, parametrised traffic generator for the ROWS×COLUMNS mesh router. It drives every mesh terminal's input side (pndng/data_out/popin handshake) from a per-terminal holding register. It issues packets in one of four run-time modes: single packet, round-robin many-to-many, FIFO fill and broadcast. It replaces instruction-driven software stimulus for on-chip self-test and long-run soak, and reports issue progress and completion.

---
 rtl/mesh_tgen_pkg.sv | 60 ++++++
 rtl/mesh_traffic_gen_if.sv | 13 +
 rtl/mesh_tgen_slot.sv | 33 +++
 rtl/mesh_traffic_gen.sv | 145 ++++++++++++++
 tb/tb_mesh_traffic_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_tgen_pkg.sv
// Shared types and packet/address helpers for the mesh traffic generator.
// Pure declarations and functions: no latency, no flow control.
package mesh_tgen_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_RR     = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BCAST  = 2'd3
    } tgen_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } tgen_state_e;

    localparam int NJ_W    = 8;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int MODE_W  = 1;
    localparam int HDR_W   = NJ_W + ROW_W + COL_W + MODE_W;
    localparam int PKT_MAX = 64;

    // Mesh coordinates of terminal t, walking top, left, bottom, right edges.
    function automatic logic [7:0] term_addr(input int t, input int rows, input int cols);
        int r;
        int c;
        if (t < cols) begin
            r = 0;                  c = t + 1;
        end else if (t < cols + rows) begin
            r = t - cols + 1;       c = 0;
        end else if (t < 2*cols + rows) begin
            r = rows + 1;           c = t - cols - rows + 1;
        end else begin
            r = t - 2*cols - rows + 1; c = cols + 1;
        end
        return {4'(r), 4'(c)};
    endfunction

    // Packet is built MSB-aligned in PKT_MAX bits, then shifted down so the
    // caller keeps the low pakg_size bits. Payload keeps the low count bits.
    function automatic logic [PKT_MAX-1:0] build_pkt(input logic [7:0] dst, input logic [7:0] src,
                                                     input logic [31:0] seq, input int pakg_size,
                                                     input int term_w);
        int pw;
        int sw;
        logic [PKT_MAX-1:0] seqm;
        logic [PKT_MAX-1:0] pl;
        logic [PKT_MAX-1:0] pkt;
        pw   = pakg_size - HDR_W;
        sw   = pw - term_w;
        seqm = PKT_MAX'(seq) & ((PKT_MAX'(1) << sw) - PKT_MAX'(1));
        pl   = (PKT_MAX'(src) << (PKT_MAX - term_w)) | (seqm << (PKT_MAX - pw));
        pkt  = (PKT_MAX'(dst) << (PKT_MAX - NJ_W - ROW_W - COL_W)) | (pl >> HDR_W);
        return pkt >> (PKT_MAX - pakg_size);
    endfunction

endpackage

// File: rtl/mesh_traffic_gen_if.sv
// Mesh terminal input-side handshake: pending flag, packet, pop.
// Master holds a packet until the mesh pops it; pop without pending is ignored.
interface mesh_traffic_gen_if #(
    parameter int NTERM     = 16,
    parameter int PAKG_SIZE = 32
);
    logic [NTERM-1:0]                pndng_o;
    logic [NTERM-1:0][PAKG_SIZE-1:0] data_out_o;
    logic [NTERM-1:0]                popin_i;

    modport master (output pndng_o, output data_out_o, input popin_i);
    modport slave  (input pndng_o, input data_out_o, output popin_i);
endinterface

// File: rtl/mesh_tgen_slot.sv
// One terminal holding register; a load lands on the next edge.
// Free when empty or popped this cycle, so pop-and-load keeps pndng_o high.
module mesh_tgen_slot #(
    parameter int PAKG_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [PAKG_SIZE-1:0] load_dat_i,
    input  logic                 popin_i,
    output logic                 pndng_o,
    output logic [PAKG_SIZE-1:0] data_o,
    output logic                 free_o
);
    logic                 r_pndng;
    logic [PAKG_SIZE-1:0] r_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pndng <= 1'b0;
            r_data  <= '0;
        end else if (load_i) begin
            r_pndng <= 1'b1;
            r_data  <= load_dat_i;
        end else if (popin_i && r_pndng) begin
            r_pndng <= 1'b0;
        end
    end

    assign pndng_o = r_pndng;
    assign data_o  = r_data;
    assign free_o  = !r_pndng || popin_i;
endmodule

// File: rtl/mesh_traffic_gen.sv
// Mesh traffic generator (SINGLE/RR/FILL/BCAST); TGEN_LFSR_EN picks pseudo-random RR destinations.
// First load one edge after start; a busy source slot stalls issue until the mesh pops it.
module mesh_traffic_gen
    import mesh_tgen_pkg::*;
#(
    parameter int         ROWS      = 4,
    parameter int         COLUMNS   = 4,
    parameter int         PAKG_SIZE = 32,
    parameter logic [7:0] BDCST     = 8'hFF,
    parameter int         CNT_W     = 16,
    localparam int        NTERM     = 2*(ROWS+COLUMNS),
    localparam int        TERM_W    = $clog2(NTERM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [TERM_W-1:0]    src_i,
    input  logic [TERM_W-1:0]    dst_i,
    input  logic [CNT_W-1:0]     num_pkts_i,
    mesh_traffic_gen_if.master   mesh,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     sent_cnt_o
);
    tgen_state_e       r_state;
    tgen_mode_e        r_mode;
    logic [TERM_W-1:0] r_src;
    logic [TERM_W-1:0] r_dst;
    logic [TERM_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    logic [NTERM-1:0]     w_free;
    logic [NTERM-1:0]     w_load;
    logic [TERM_W-1:0]    w_src;
    logic [TERM_W-1:0]    w_rr_dst;
    logic [7:0]           w_dst_addr;
    logic [PAKG_SIZE-1:0] w_pkt;
    logic [CNT_W-1:0]     w_target;
    logic                 w_do_load;

    assign w_src     = (r_mode == MODE_RR) ? r_rr_ptr : r_src;
    assign w_do_load = (r_state == ST_ISSUE) && w_free[w_src];
    assign w_load    = w_do_load ? (NTERM'(1) << w_src) : '0;
    assign w_target  = (r_mode == MODE_RR || r_mode == MODE_FILL) ? r_num : CNT_W'(1);

`ifdef TGEN_LFSR_EN
    logic [15:0] r_lfsr;

    // Offset range 1..NTERM-1 keeps the RR destination off its own source.
    assign w_rr_dst = TERM_W'((int'(w_src) + 1 + int'(r_lfsr) % (NTERM-1)) % NTERM);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= 16'hACE1;
        end else if (w_do_load && r_mode == MODE_RR) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`else
    logic [TERM_W-1:0] w_off;

    assign w_off    = (r_dst == '0) ? TERM_W'(1) : r_dst;
    assign w_rr_dst = TERM_W'((int'(w_src) + int'(w_off)) % NTERM);
`endif

    always_comb begin
        w_dst_addr = term_addr(int'(r_dst), ROWS, COLUMNS);
        case (r_mode)
            MODE_BCAST: w_dst_addr = BDCST;
            MODE_RR:    w_dst_addr = term_addr(int'(w_rr_dst), ROWS, COLUMNS);
            default:    ;
        endcase
    end

    assign w_pkt = PAKG_SIZE'(build_pkt(w_dst_addr, 8'(w_src), 32'(r_cnt), PAKG_SIZE, TERM_W));

    for (genvar g = 0; g < NTERM; g++) begin : g_slot
        mesh_tgen_slot #(.PAKG_SIZE(PAKG_SIZE)) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (w_load[g]),
            .load_dat_i (w_pkt),
            .popin_i    (mesh.popin_i[g]),
            .pndng_o    (mesh.pndng_o[g]),
            .data_o     (mesh.data_out_o[g]),
            .free_o     (w_free[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_SINGLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_rr_ptr <= '0;
            r_num    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start_i) begin
                    r_mode <= tgen_mode_e'(mode_i);
                    r_src  <= src_i;
                    r_dst  <= dst_i;
                    r_num  <= num_pkts_i;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                    if ((mode_i == MODE_RR || mode_i == MODE_FILL) && num_pkts_i == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: if (w_do_load) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_mode == MODE_RR)
                        r_rr_ptr <= (r_rr_ptr == TERM_W'(NTERM-1)) ? '0 : r_rr_ptr + 1'b1;
                    if (CNT_W'(r_cnt + 1'b1) == w_target)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (mesh.pndng_o == '0) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign sent_cnt_o = r_cnt;
endmodule

// File: tb/tb_mesh_traffic_gen.sv
// Directed bench for mesh_traffic_gen on a 4x4 mesh (16 terminals, 32-bit packets).
// Packets expected as {8'h00, row, col, 1'b0, src[3:0], seq[10:0]}, seq = count before the load.
module tb_mesh_traffic_gen;
    localparam int NTERM     = 16;
    localparam int PAKG_SIZE = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [3:0]  src_i = 4'd0;
    logic [3:0]  dst_i = 4'd0;
    logic [15:0] num_pkts_i = 16'd0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sent_cnt_o;

    mesh_traffic_gen_if #(.NTERM(NTERM), .PAKG_SIZE(PAKG_SIZE)) mesh ();

    mesh_traffic_gen #(
        .ROWS(4), .COLUMNS(4), .PAKG_SIZE(PAKG_SIZE), .BDCST(8'hFF), .CNT_W(16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .num_pkts_i (num_pkts_i),
        .mesh       (mesh),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sent_cnt_o (sent_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  src;
        logic [3:0]  dst;
        int          hold;
        logic [31:0] exp_pkt;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] addr_tab[16];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pkt(input logic [7:0] d, input logic [3:0] s, input logic [10:0] q);
        return {8'h00, d, 1'b0, s, q};
    endfunction

    task automatic run_vec(input vec_t v);
        logic held;
        start_i = 1'b1; mode_i = v.mode; src_i = v.src; dst_i = v.dst; num_pkts_i = 16'd7;
        step();
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(1));
        chk("no_load_at_start", 64'(mesh.pndng_o), 64'(0));
        step();
        chk("pndng_onehot", 64'(mesh.pndng_o), 64'(16'(1) << v.src));
        chk("pkt_data", 64'(mesh.data_out_o[v.src]), 64'(v.exp_pkt));
        held = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (mesh.pndng_o[v.src] !== 1'b1) held = 1'b0;
        end
        chk("pndng_held", 64'(held), 64'(1));
        mesh.popin_i[v.src] = 1'b1;
        step();
        mesh.popin_i = '0;
        chk("pop_clears", 64'(mesh.pndng_o), 64'(0));
        chk("no_early_done", 64'(done_o), 64'(0));
        step();
        chk("done_pulse", 64'(done_o), 64'(1));
        chk("sent_cnt_single", 64'(sent_cnt_o), 64'(1));
        step();
        chk("done_one_cycle", 64'(done_o), 64'(0));
        chk("busy_falls", 64'(busy_o), 64'(0));
    endtask

    initial begin
        int nload;
        int ndone;
        int s;
        int last;
        int drops;
        int badsp;
        int others;
        logic [15:0] pv;
        logic [15:0] prev;
        logic got;

        addr_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                     8'h51, 8'h52, 8'h53, 8'h54, 8'h15, 8'h25, 8'h35, 8'h45};
        vecs[0] = '{2'd0, 4'd0,  4'd6,  20, 32'h0030_0000};
        vecs[1] = '{2'd0, 4'd3,  4'd0,  2,  32'h0001_1800};
        vecs[2] = '{2'd0, 4'd15, 4'd11, 1,  32'h0054_7800};
        vecs[3] = '{2'd0, 4'd8,  4'd13, 3,  32'h0025_4000};
        vecs[4] = '{2'd3, 4'd2,  4'd9,  2,  32'h00FF_1000};
        vecs[5] = '{2'd0, 4'd4,  4'd4,  1,  32'h0010_2000};
        mesh.popin_i = '0;

        step(); step();
        chk("rst_pndng", 64'(mesh.pndng_o), 64'(0));
        chk("rst_data", 64'(|mesh.data_out_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_cnt", 64'(sent_cnt_o), 64'(0));
        rst_i = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // RR, offset 3, mesh popping every cycle: one fresh slot visible per cycle.
        nload = 0; ndone = 0;
        mode_i = 2'd1; dst_i = 4'd3; num_pkts_i = 16'd32; start_i = 1'b1; mesh.popin_i = '1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            pv = mesh.pndng_o;
            if (done_o) ndone++;
            if (pv != 16'd0) begin
                s = nload % 16;
                chk("rr_onehot", 64'(pv), 64'(16'(1) << s));
                chk("rr_pkt", 64'(mesh.data_out_o[s]), 64'(pkt(addr_tab[(s + 3) % 16], 4'(s), 11'(nload))));
                nload++;
            end
        end
        mesh.popin_i = '0;
        chk("rr_loads", 64'(nload), 64'(32));
        chk("rr_done_count", 64'(ndone), 64'(1));
        chk("rr_sent_cnt", 64'(sent_cnt_o), 64'(32));
        chk("rr_idle", 64'(busy_o), 64'(0));

        // FILL src 5 -> dst 12, pops every 4th cycle: reloads ride on the pops.
        nload = 0; ndone = 0; drops = 0; badsp = 0; others = 0; last = 0; prev = 16'd0;
        mode_i = 2'd2; src_i = 4'd5; dst_i = 4'd12; num_pkts_i = 16'd16; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            mesh.popin_i = '0;
            if (c % 4 == 3) mesh.popin_i[5] = 1'b1;
            step();
            if (sent_cnt_o != prev) begin
                nload++;
                chk("fill_pkt", 64'(mesh.data_out_o[5]), 64'(pkt(8'h15, 4'd5, 11'(nload - 1))));
                if (nload > 2 && c - last != 4) badsp++;
                last = c;
                prev = sent_cnt_o;
            end
            if (c == 2) chk("fill_stall_one_load", 64'(sent_cnt_o), 64'(1));
            if (nload > 0 && nload < 16 && !mesh.pndng_o[5]) drops++;
            if ((mesh.pndng_o & ~16'h0020) != 16'd0) others++;
            if (done_o) ndone++;
        end
        mesh.popin_i = '0;
        chk("fill_loads", 64'(nload), 64'(16));
        chk("fill_spacing", 64'(badsp), 64'(0));
        chk("fill_no_drop", 64'(drops), 64'(0));
        chk("fill_other_slots", 64'(others), 64'(0));
        chk("fill_done_count", 64'(ndone), 64'(1));

        // RR of 100 with reset asserted at load 50.
        got = 1'b0;
        mode_i = 2'd1; dst_i = 4'd1; num_pkts_i = 16'd100; start_i = 1'b1; mesh.popin_i = '1;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            if (sent_cnt_o == 16'd50) got = 1'b1;
        end
        chk("rst_reach_50", 64'(got), 64'(1));
        rst_i = 1'b0;
        mesh.popin_i = '0;
        #1;
        chk("midrst_pndng", 64'(mesh.pndng_o), 64'(0));
        chk("midrst_data", 64'(|mesh.data_out_o), 64'(0));
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_cnt", 64'(sent_cnt_o), 64'(0));
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done_o) ndone++;
        end
        rst_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done_o || busy_o) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'(0));
        run_vec(vecs[0]);

        // start while busy is ignored; zero-length FILL finishes straight away.
        start_i = 1'b1; mode_i = 2'd0; src_i = 4'd1; dst_i = 4'd2;
        step();
        start_i = 1'b0;
        step();
        mode_i = 2'd1; num_pkts_i = 16'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("busy_start_cnt", 64'(sent_cnt_o), 64'(1));
        chk("busy_start_pndng", 64'(mesh.pndng_o), 64'(16'h0002));
        chk("busy_start_data", 64'(mesh.data_out_o[1]), 64'(32'h0003_0800));
        mesh.popin_i[1] = 1'b1;
        step();
        mesh.popin_i = '0;
        step();
        chk("busy_start_done", 64'(done_o), 64'(1));
        step();
        mode_i = 2'd2; num_pkts_i = 16'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("zero_done", 64'(done_o), 64'(1));
        chk("zero_busy", 64'(busy_o), 64'(1));
        chk("zero_cnt", 64'(sent_cnt_o), 64'(0));
        chk("zero_pndng", 64'(mesh.pndng_o), 64'(0));
        step();
        chk("zero_done_end", 64'(done_o), 64'(0));
        chk("zero_idle", 64'(busy_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err);
        $fatal(1, "timeout");
    end
endmodule
